mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: IF/ID/EX/MEM/WB with memory wait states.
// Define MC_CTRL_MDU_EN to add mult/div/mfhi/mflo and the MDW wait state.
module mc_ctrl #(
  parameter int MEM_LAT = 1,
  parameter int MDU_LAT = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic [2:0]  state,
  output logic        PCWrite,
  output logic        Branch,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        EXTsign,
  output logic [1:0]  ALUOp,
  output logic        ALUSrc,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  DMOp,
  output logic [1:0]  NPCOp,
  output logic        md_start,
  output logic [1:0]  md_op,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_MDW = 3'd5
  } state_t;

  localparam logic [3:0] MEM_LAST = 4'(MEM_LAT - 1);
  localparam logic [3:0] MDU_LAST = 4'(MDU_LAT - 1);

  state_t     cur, nxt;
  logic [3:0] cnt;

  logic [5:0] op, fn;
  logic i_add, i_sub, i_ori, i_lui;
  logic i_ld, i_st, i_beq;
  logic i_j, i_jal, i_jr, i_jalr;
  logic i_md, i_mf;
  logic [1:0] dm_w, md_sel;
  logic is_alu, is_jmp, known;
  logic [1:0] aluop_d;
  logic alusrc_d, ext_d;
  logic mem_last;
  logic unused_bits;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign unused_bits = ^instr[25:6];

  always_comb begin
    i_add  = 1'b0;
    i_sub  = 1'b0;
    i_ori  = 1'b0;
    i_lui  = 1'b0;
    i_ld   = 1'b0;
    i_st   = 1'b0;
    i_beq  = 1'b0;
    i_j    = 1'b0;
    i_jal  = 1'b0;
    i_jr   = 1'b0;
    i_jalr = 1'b0;
    i_md   = 1'b0;
    i_mf   = 1'b0;
    dm_w   = 2'd0;
    md_sel = 2'd0;
    case (op)
      6'h00: begin
        case (fn)
          6'h20: i_add  = 1'b1;
          6'h22: i_sub  = 1'b1;
          6'h08: i_jr   = 1'b1;
          6'h09: i_jalr = 1'b1;
`ifdef MC_CTRL_MDU_EN
          6'h18: begin i_md = 1'b1; md_sel = 2'd0; end
          6'h1a: begin i_md = 1'b1; md_sel = 2'd1; end
          6'h10: begin i_mf = 1'b1; md_sel = 2'd2; end
          6'h12: begin i_mf = 1'b1; md_sel = 2'd3; end
`endif
          default: ;
        endcase
      end
      6'h0d: i_ori = 1'b1;
      6'h0f: i_lui = 1'b1;
      6'h23: begin i_ld = 1'b1; dm_w = 2'd0; end
      6'h21: begin i_ld = 1'b1; dm_w = 2'd1; end
      6'h20: begin i_ld = 1'b1; dm_w = 2'd2; end
      6'h2b: begin i_st = 1'b1; dm_w = 2'd0; end
      6'h29: begin i_st = 1'b1; dm_w = 2'd1; end
      6'h28: begin i_st = 1'b1; dm_w = 2'd2; end
      6'h04: i_beq = 1'b1;
      6'h02: i_j   = 1'b1;
      6'h03: i_jal = 1'b1;
      default: ;
    endcase
  end

  assign is_alu = i_add | i_sub | i_ori | i_lui | i_mf;
  assign is_jmp = i_j | i_jal | i_jr | i_jalr;
  assign known  = is_alu | is_jmp | i_ld | i_st | i_beq | i_md;

  // Operand controls are a pure function of the IR so they hold steady
  // from ID until the instruction retires.
  assign aluop_d  = (i_sub | i_beq) ? 2'd1 :
                    i_ori ? 2'd2 :
                    i_lui ? 2'd3 : 2'd0;
  assign alusrc_d = i_ori | i_lui | i_ld | i_st;
  assign ext_d    = i_beq | i_ld | i_st;
  assign mem_last = (cnt == MEM_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= S_IF;
      cnt <= 4'd0;
    end else begin
      cur <= nxt;
      cnt <= (nxt != cur) ? 4'd0 : cnt + 4'd1;
    end
  end

  always_comb begin
    nxt = S_IF;
    unique case (cur)
      S_IF:  nxt = mem_last ? S_ID : S_IF;
      S_ID:  nxt = (is_jmp || !known) ? S_IF : S_EX;
      S_EX: begin
        unique case (1'b1)
          i_beq:        nxt = S_IF;
          is_alu:       nxt = S_WB;
          (i_ld | i_st): nxt = S_MEM;
          i_md:         nxt = S_MDW;
          default:      nxt = S_IF;
        endcase
      end
      S_MEM: nxt = !mem_last ? S_MEM : (i_ld ? S_WB : S_IF);
      S_WB:  nxt = S_IF;
      S_MDW: nxt = (cnt == MDU_LAST) ? S_IF : S_MDW;
      default: nxt = S_IF;
    endcase
  end

  assign state = cur;

  always_comb begin
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    EXTsign  = 1'b0;
    ALUOp    = 2'd0;
    ALUSrc   = 1'b0;
    RegDst   = 2'd0;
    MemtoReg = 2'd0;
    DMOp     = 2'd0;
    NPCOp    = 2'd0;
    md_start = 1'b0;
    md_op    = 2'd0;
    busy     = 1'b0;
    // Reset masks every strobe so nothing leaks out mid-instruction.
    if (!reset) begin
      if (cur != S_IF) begin
        ALUOp   = aluop_d;
        ALUSrc  = alusrc_d;
        EXTsign = ext_d;
        DMOp    = dm_w;
        md_op   = md_sel;
      end
      unique case (cur)
        S_IF: begin
          MemRead = 1'b1;
          if (mem_last) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
          end
        end
        S_ID: begin
          if (is_jmp) begin
            PCWrite = 1'b1;
            NPCOp   = (i_jr | i_jalr) ? 2'd3 : 2'd2;
          end
          if (i_jal) begin
            RegWrite = 1'b1;
            RegDst   = 2'd2;
            MemtoReg = 2'd2;
          end
          if (i_jalr) begin
            RegWrite = 1'b1;
            RegDst   = 2'd1;
            MemtoReg = 2'd2;
          end
        end
        S_EX: begin
          if (i_beq) begin
            Branch = 1'b1;
            NPCOp  = 2'd1;
          end
          md_start = i_md;
        end
        S_MEM: begin
          MemRead  = i_ld;
          MemWrite = i_st & mem_last;
        end
        S_WB: begin
          RegWrite = 1'b1;
          RegDst   = (i_add | i_sub | i_mf) ? 2'd1 : 2'd0;
          MemtoReg = i_ld ? 2'd1 : (i_mf ? 2'd3 : 2'd0);
        end
        S_MDW: busy = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed table-driven bench for mc_ctrl at MEM_LAT=1 and MEM_LAT=3.
// Mult/mfhi expectations follow MC_CTRL_MDU_EN.
module tb_mc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [31:0] instr_a = 32'h0;
  logic [31:0] instr_b = 32'h0;
  bit          sel = 1'b0;

  logic [2:0] state_a, state_b;
  logic pcw_a, br_a, irw_a, rw_a, mr_a, mw_a, ext_a, src_a;
  logic pcw_b, br_b, irw_b, rw_b, mr_b, mw_b, ext_b, src_b;
  logic [1:0] aop_a, rd_a, mtr_a, dm_a, npc_a, mdop_a;
  logic [1:0] aop_b, rd_b, mtr_b, dm_b, npc_b, mdop_b;
  logic mds_a, busy_a, mds_b, busy_b;

  mc_ctrl #(.MEM_LAT(1), .MDU_LAT(5)) dut_a (
    .clk(clk), .reset(reset), .instr(instr_a), .state(state_a),
    .PCWrite(pcw_a), .Branch(br_a), .IRWrite(irw_a),
    .RegWrite(rw_a), .MemRead(mr_a), .MemWrite(mw_a),
    .EXTsign(ext_a), .ALUOp(aop_a), .ALUSrc(src_a),
    .RegDst(rd_a), .MemtoReg(mtr_a), .DMOp(dm_a), .NPCOp(npc_a),
    .md_start(mds_a), .md_op(mdop_a), .busy(busy_a)
  );

  mc_ctrl #(.MEM_LAT(3), .MDU_LAT(5)) dut_b (
    .clk(clk), .reset(reset), .instr(instr_b), .state(state_b),
    .PCWrite(pcw_b), .Branch(br_b), .IRWrite(irw_b),
    .RegWrite(rw_b), .MemRead(mr_b), .MemWrite(mw_b),
    .EXTsign(ext_b), .ALUOp(aop_b), .ALUSrc(src_b),
    .RegDst(rd_b), .MemtoReg(mtr_b), .DMOp(dm_b), .NPCOp(npc_b),
    .md_start(mds_b), .md_op(mdop_b), .busy(busy_b)
  );

  logic [24:0] outs_a, outs_b, ob;
  assign outs_a = {state_a, pcw_a, br_a, irw_a, rw_a, mr_a, mw_a,
                   ext_a, aop_a, src_a, rd_a, mtr_a, dm_a, npc_a,
                   mds_a, mdop_a, busy_a};
  assign outs_b = {state_b, pcw_b, br_b, irw_b, rw_b, mr_b, mw_b,
                   ext_b, aop_b, src_b, rd_b, mtr_b, dm_b, npc_b,
                   mds_b, mdop_b, busy_b};
  assign ob = sel ? outs_b : outs_a;

  logic [2:0] o_state;
  logic o_pcw, o_br, o_rw, o_mr, o_mw, o_ext, o_src, o_mds, o_busy;
  logic [1:0] o_aop, o_rd, o_mtr, o_dm, o_npc;
  assign o_state = ob[24:22];
  assign o_pcw   = ob[21];
  assign o_br    = ob[20];
  assign o_rw    = ob[18];
  assign o_mr    = ob[17];
  assign o_mw    = ob[16];
  assign o_ext   = ob[15];
  assign o_aop   = ob[14:13];
  assign o_src   = ob[12];
  assign o_rd    = ob[11:10];
  assign o_mtr   = ob[9:8];
  assign o_dm    = ob[7:6];
  assign o_npc   = ob[5:4];
  assign o_mds   = ob[3];
  assign o_busy  = ob[0];

  typedef struct {
    bit          dut;
    logic [31:0] ins;
    int          len;
    logic [39:0] st;
    int nrw, rd, mtr, nmw, mwat, npcw, npc, nmr, nbr;
    int aop, src, ext, dm, nmds, nbusy;
  } vec_t;

  vec_t vecs[$];
  int passed = 0;
  int total = 0;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic vec_t mk(
    input bit d, input logic [31:0] ins, input int len,
    input logic [39:0] st, input int nrw, input int rd, input int mtr,
    input int nmw, input int mwat, input int npcw, input int npc,
    input int nmr, input int nbr, input int aop, input int src,
    input int ext, input int dm, input int nmds, input int nbusy);
    vec_t v;
    v.dut = d; v.ins = ins; v.len = len; v.st = st;
    v.nrw = nrw; v.rd = rd; v.mtr = mtr; v.nmw = nmw; v.mwat = mwat;
    v.npcw = npcw; v.npc = npc; v.nmr = nmr; v.nbr = nbr;
    v.aop = aop; v.src = src; v.ext = ext; v.dm = dm;
    v.nmds = nmds; v.nbusy = nbusy;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_outs_a", longint'(outs_a), 0);
    chk("reset_outs_b", longint'(outs_b), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [39:0] tr = '0;
    logic [1:0] rd = 2'd0, mtr = 2'd0;
    int nrw = 0, nmw = 0, mwat = -1, npcw = 0, nmr = 0, nbr = 0;
    int nmds = 0, nbusy = 0, bad_attr = 0, bad_npc = 0;
    sel = v.dut;
    if (v.dut) instr_b = v.ins;
    else instr_a = v.ins;
    for (int c = 0; c < v.len; c++) begin
      @(negedge clk);
      tr = {tr[35:0], 1'b0, o_state};
      if (o_rw) begin
        nrw++;
        rd = o_rd;
        mtr = o_mtr;
      end
      if (o_mw) begin
        nmw++;
        mwat = c;
      end
      npcw  += int'(o_pcw);
      nmr   += int'(o_mr);
      nbr   += int'(o_br);
      nmds  += int'(o_mds);
      nbusy += int'(o_busy);
      if (o_state != 3'd0 &&
          (int'(o_aop) != v.aop || int'(o_src) != v.src ||
           int'(o_ext) != v.ext || int'(o_dm) != v.dm))
        bad_attr++;
      if ((o_pcw || o_br) &&
          int'(o_npc) != (o_state == 3'd0 ? 0 : v.npc))
        bad_npc++;
      @(posedge clk);
      #1;
    end
    chk($sformatf("v%0d_trace", idx), longint'(tr), longint'(v.st));
    chk($sformatf("v%0d_back_to_if", idx), longint'(o_state), 0);
    chk($sformatf("v%0d_regwrite_n", idx), nrw, v.nrw);
    chk($sformatf("v%0d_regdst", idx), longint'(rd), v.rd);
    chk($sformatf("v%0d_memtoreg", idx), longint'(mtr), v.mtr);
    chk($sformatf("v%0d_memwrite_n", idx), nmw, v.nmw);
    chk($sformatf("v%0d_memwrite_at", idx), mwat, v.mwat);
    chk($sformatf("v%0d_pcwrite_n", idx), npcw, v.npcw);
    chk($sformatf("v%0d_memread_n", idx), nmr, v.nmr);
    chk($sformatf("v%0d_branch_n", idx), nbr, v.nbr);
    chk($sformatf("v%0d_md_start_n", idx), nmds, v.nmds);
    chk($sformatf("v%0d_busy_n", idx), nbusy, v.nbusy);
    chk($sformatf("v%0d_attr_bad", idx), bad_attr, 0);
    chk($sformatf("v%0d_npcop_bad", idx), bad_npc, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rw_seen;
    // MEM_LAT=1 instance
    vecs.push_back(mk(0, 32'h00221820, 4, 40'h0124, 1, 1, 0, 0, -1,
                      1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h00221822, 4, 40'h0124, 1, 1, 0, 0, -1,
                      1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h34220010, 4, 40'h0124, 1, 0, 0, 0, -1,
                      1, 0, 1, 0, 2, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h3C021234, 4, 40'h0124, 1, 0, 0, 0, -1,
                      1, 0, 1, 0, 3, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h8C220004, 5, 40'h01234, 1, 0, 1, 0, -1,
                      1, 0, 2, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 32'h84220004, 5, 40'h01234, 1, 0, 1, 0, -1,
                      1, 0, 2, 0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 32'h80220004, 5, 40'h01234, 1, 0, 1, 0, -1,
                      1, 0, 2, 0, 0, 1, 1, 2, 0, 0));
    vecs.push_back(mk(0, 32'hAC220004, 4, 40'h0123, 0, 0, 0, 1, 3,
                      1, 0, 1, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 32'hA4220004, 4, 40'h0123, 0, 0, 0, 1, 3,
                      1, 0, 1, 0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 32'h10220003, 3, 40'h012, 0, 0, 0, 0, -1,
                      1, 1, 1, 1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 32'h08000010, 2, 40'h01, 0, 0, 0, 0, -1,
                      2, 2, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0C000010, 2, 40'h01, 1, 2, 2, 0, -1,
                      2, 2, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h03E00008, 2, 40'h01, 0, 0, 0, 0, -1,
                      2, 3, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0020F809, 2, 40'h01, 1, 1, 2, 0, -1,
                      2, 3, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'hFC000000, 2, 40'h01, 0, 0, 0, 0, -1,
                      1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
`ifdef MC_CTRL_MDU_EN
    vecs.push_back(mk(0, 32'h00220018, 8, 40'h01255555, 0, 0, 0, 0, -1,
                      1, 0, 1, 0, 0, 0, 0, 0, 1, 5));
    vecs.push_back(mk(0, 32'h00001810, 4, 40'h0124, 1, 1, 3, 0, -1,
                      1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
`else
    vecs.push_back(mk(0, 32'h00220018, 2, 40'h01, 0, 0, 0, 0, -1,
                      1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h00001810, 2, 40'h01, 0, 0, 0, 0, -1,
                      1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
`endif
    // MEM_LAT=3 instance
    vecs.push_back(mk(1, 32'hAC220004, 8, 40'h00012333, 0, 0, 0, 1, 7,
                      1, 0, 3, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h8C220004, 9, 40'h000123334, 1, 0, 1, 0, -1,
                      1, 0, 6, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'h00221820, 6, 40'h000124, 1, 1, 0, 0, -1,
                      1, 0, 3, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 0 || vecs[i].dut != vecs[i-1].dut) do_reset();
      run_vec(vecs[i], i);
    end

    // lw on MEM_LAT=3, reset asserted between edges in the 2nd MEM cycle
    do_reset();
    sel = 1'b1;
    instr_b = 32'h8C220004;
    rw_seen = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      rw_seen += int'(o_rw);
      if (c < 6) begin
        @(posedge clk);
        #1;
      end
    end
    chk("midmem_in_mem", longint'(o_state), 3);
    #2;
    reset = 1'b1;
    #1;
    chk("midmem_async_outs", longint'(outs_b), 0);
    chk("midmem_no_regwrite", rw_seen, 0);
    @(posedge clk);
    #1;
    chk("midmem_held_outs", longint'(outs_b), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_state", longint'(o_state), 0);
    chk("post_reset_memread", longint'(o_mr), 1);
    chk("post_reset_regwrite", longint'(o_rw), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
